// File: rtl/nanorv32_sim_pkg.sv
// Shared types and default constants for the nanorv32 simulation memory model.
package nanorv32_sim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sim_state_t;

    localparam logic [31:0] DEF_OUT_ADDR   = 32'h1000_0000;
    localparam logic [31:0] DEF_PASS_ADDR  = 32'h2000_0000;
    localparam logic [31:0] DEF_PASS_VALUE = 32'd123456789;

    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/nanorv32_sim_lfsr.sv
// 16-bit Galois LFSR with enable; the current state is exposed for random stall injection.
module nanorv32_sim_lfsr
    import nanorv32_sim_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = lfsr_reg;
        if (en) begin
            lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_TAPS) : (lfsr_reg >> 1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign state = lfsr_reg;

endmodule

// File: rtl/nanorv32_sim_mem.sv
// Simulation RAM + console/pass-marker MMIO on the nanorv32 native bus, with wait states.
// Define SIM_MEM_RAND_STALL_EN to add 0-3 random extra wait states per access.
module nanorv32_sim_mem
    import nanorv32_sim_pkg::*;
#(
    parameter int          MEM_BYTES  = 131072,
    parameter int          LATENCY    = 0,
    parameter logic [31:0] OUT_ADDR   = DEF_OUT_ADDR,
    parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_VALUE = DEF_PASS_VALUE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        tests_passed,
    output logic        oob_error,
    output logic [31:0] oob_addr,
    output logic        proto_error
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = 5;

    sim_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_load;
    logic [31:0]      addr_reg, wdata_reg;
    logic [3:0]       wstrb_reg;
    logic [31:0]      mem_rdata_reg;
    logic             out_valid_reg, tests_passed_reg, oob_error_reg, proto_error_reg;
    logic [7:0]       out_data_reg;
    logic [31:0]      oob_addr_reg;

    logic        do_access, set_proto, latch_req;
    logic [31:0] acc_addr, acc_wdata, rdata_next, ram_rd_word;
    logic [3:0]  acc_wstrb;
    logic        in_ram, is_out, is_pass, ram_we;
    logic [IW-1:0] ram_idx;

`ifdef SIM_MEM_RAND_STALL_EN
    logic [15:0] lfsr_state;
    logic        unused_lfsr;

    nanorv32_sim_lfsr u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .en     (1'b1),
        .state  (lfsr_state)
    );

    assign cnt_load    = CNT_W'(LATENCY) + CNT_W'(lfsr_state[1:0]);
    assign unused_lfsr = ^lfsr_state[15:2];
`else
    assign cnt_load = CNT_W'(LATENCY);
`endif

    logic unused_instr;
    assign unused_instr = mem_instr;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_req  = 1'b0;
        do_access  = 1'b0;
        set_proto  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_valid) begin
                    latch_req = 1'b1;
                    cnt_next  = cnt_load;
                    if (cnt_load == '0) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    set_proto  = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Zero-latency accesses happen on the accepting edge, so use the live bus then
    assign acc_addr  = (state_reg == IDLE) ? mem_addr  : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? mem_wdata : wdata_reg;
    assign acc_wstrb = (state_reg == IDLE) ? mem_wstrb : wstrb_reg;

    assign in_ram  = acc_addr < 32'(MEM_BYTES);
    assign is_out  = !in_ram && (acc_addr == OUT_ADDR);
    assign is_pass = !in_ram && !is_out && (acc_addr == PASS_ADDR);
    assign ram_idx = acc_addr[IW+1:2];
    assign ram_we  = do_access && in_ram && resetn;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];

            always_ff @(posedge clk) begin
                if (ram_we && acc_wstrb[gi]) begin
                    lane_mem[ram_idx] <= acc_wdata[8*gi +: 8];
                end
            end

            assign ram_rd_word[8*gi +: 8] = lane_mem[ram_idx];
        end
    endgenerate

    always_comb begin
        rdata_next = '0;
        if (in_ram) begin
            rdata_next = ram_rd_word;
        end else if (is_pass) begin
            rdata_next = {31'b0, tests_passed_reg};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            wstrb_reg        <= '0;
            mem_rdata_reg    <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            tests_passed_reg <= 1'b0;
            oob_error_reg    <= 1'b0;
            oob_addr_reg     <= '0;
            proto_error_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= do_access && is_out && (acc_wstrb != 4'b0000);
            if (latch_req) begin
                addr_reg  <= mem_addr;
                wdata_reg <= mem_wdata;
                wstrb_reg <= mem_wstrb;
            end
            if (do_access) begin
                mem_rdata_reg <= rdata_next;
                if (is_out && (acc_wstrb != 4'b0000)) begin
                    out_data_reg <= acc_wdata[7:0];
                end
                if (is_pass && (acc_wstrb == 4'b1111) && (acc_wdata == PASS_VALUE)) begin
                    tests_passed_reg <= 1'b1;
                end
                if (!in_ram && !is_out && !is_pass) begin
                    oob_error_reg <= 1'b1;
                    if (!oob_error_reg) begin
                        oob_addr_reg <= acc_addr;
                    end
                end
            end
            if (set_proto) begin
                proto_error_reg <= 1'b1;
            end
        end
    end

    assign mem_ready    = (state_reg == RESP);
    assign mem_rdata    = mem_rdata_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign tests_passed = tests_passed_reg;
    assign oob_error    = oob_error_reg;
    assign oob_addr     = oob_addr_reg;
    assign proto_error  = proto_error_reg;

endmodule

// File: tb/tb_nanorv32_sim_mem.sv
// Bench for nanorv32_sim_mem: three instances (LATENCY 0, 3, 4), directed plan plus random RAM traffic.
module tb_nanorv32_sim_mem;

    localparam int ND = 3;

    logic                 clk;
    logic [ND-1:0]        resetn;
    logic [ND-1:0]        mem_valid;
    logic [ND-1:0]        mem_instr;
    logic [ND-1:0][31:0]  mem_addr;
    logic [ND-1:0][31:0]  mem_wdata;
    logic [ND-1:0][3:0]   mem_wstrb;
    logic [ND-1:0]        mem_ready;
    logic [ND-1:0][31:0]  mem_rdata;
    logic [ND-1:0]        out_valid;
    logic [ND-1:0][7:0]   out_data;
    logic [ND-1:0]        tests_passed;
    logic [ND-1:0]        oob_error;
    logic [ND-1:0][31:0]  oob_addr;
    logic [ND-1:0]        proto_error;

    int n_checks = 0;
    int n_fail   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            nanorv32_sim_mem #(
                .LATENCY ((gi == 0) ? 0 : ((gi == 1) ? 3 : 4))
            ) u_dut (
                .clk          (clk),
                .resetn       (resetn[gi]),
                .mem_valid    (mem_valid[gi]),
                .mem_instr    (mem_instr[gi]),
                .mem_addr     (mem_addr[gi]),
                .mem_wdata    (mem_wdata[gi]),
                .mem_wstrb    (mem_wstrb[gi]),
                .mem_ready    (mem_ready[gi]),
                .mem_rdata    (mem_rdata[gi]),
                .out_valid    (out_valid[gi]),
                .out_data     (out_data[gi]),
                .tests_passed (tests_passed[gi]),
                .oob_error    (oob_error[gi]),
                .oob_addr     (oob_addr[gi]),
                .proto_error  (proto_error[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction; returns what was on the bus in the mem_ready cycle
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output logic ov, output logic [7:0] od);
        int n;
        @(posedge clk); #1;
        mem_valid[d] = 1'b1;
        mem_addr[d]  = a;
        mem_wdata[d] = wd;
        mem_wstrb[d] = ws;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!mem_ready[d] && n < 40);
        rd = mem_rdata[d];
        ov = out_valid[d];
        od = out_data[d];
        mem_valid[d] = 1'b0;
        mem_wstrb[d] = 4'b0000;
        check($sformatf("latency d%0d a=%08h", d, a), 32'(n), 32'(lat_of(d) + 1));
        @(posedge clk); #1;
        check($sformatf("ready_pulse d%0d", d), {31'b0, mem_ready[d]}, 32'd0);
        $display("txn d%0d addr=%08h wdata=%08h wstrb=%b -> rdata=%08h out_valid=%0b out_data=%02h cycles=%0d",
                 d, a, wd, ws, rd, ov, od, n);
    endtask

    task automatic check_cleared(input int d, input string tag);
        check({tag, " mem_ready"},    {31'b0, mem_ready[d]},    32'd0);
        check({tag, " mem_rdata"},    mem_rdata[d],             32'd0);
        check({tag, " out_valid"},    {31'b0, out_valid[d]},    32'd0);
        check({tag, " out_data"},     {24'b0, out_data[d]},     32'd0);
        check({tag, " tests_passed"}, {31'b0, tests_passed[d]}, 32'd0);
        check({tag, " oob_error"},    {31'b0, oob_error[d]},    32'd0);
        check({tag, " oob_addr"},     oob_addr[d],              32'd0);
        check({tag, " proto_error"},  {31'b0, proto_error[d]},  32'd0);
    endtask

    logic [31:0] mdl [64];
    localparam logic [31:0] WIN_BASE = 32'h0000_0400;

    initial begin
        logic [31:0] rd, wd, a, expw;
        logic [3:0]  ws;
        logic        ov, seen;
        logic [7:0]  od;
        int          idx, op;

        for (int d = 0; d < ND; d++) begin
            resetn[d] = 1'b0; mem_valid[d] = 1'b0; mem_instr[d] = 1'b0;
            mem_addr[d] = '0; mem_wdata[d] = '0; mem_wstrb[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) check_cleared(d, $sformatf("reset d%0d", d));
        for (int d = 0; d < ND; d++) resetn[d] = 1'b1;

        // 1: zero latency write then read
        txn(0, 32'h100, 32'hDEADBEEF, 4'b1111, rd, ov, od);
        txn(0, 32'h100, 32'h0, 4'b0000, rd, ov, od);
        check("t1 read", rd, 32'hDEADBEEF);

        // 2: three wait states, partial strobe merge
        txn(1, 32'h200, 32'h11223344, 4'b1111, rd, ov, od);
        txn(1, 32'h200, 32'h0000AA00, 4'b0010, rd, ov, od);
        check("t2 prewrite", rd, 32'h11223344);
        txn(1, 32'h200, 32'h0, 4'b0000, rd, ov, od);
        check("t2 read", rd, 32'h1122AA44);

        // 3: console
        txn(0, 32'h1000_0000, 32'hFFFF_FF41, 4'b0001, rd, ov, od);
        check("t3 ov1", {31'b0, ov}, 32'd1);
        check("t3 od1", {24'b0, od}, 32'h41);
        txn(0, 32'h1000_0000, 32'h0000_000A, 4'b1111, rd, ov, od);
        check("t3 ov2", {31'b0, ov}, 32'd1);
        check("t3 od2", {24'b0, od}, 32'h0A);
        txn(0, 32'h1000_0000, 32'h0, 4'b0000, rd, ov, od);
        check("t3 read", rd, 32'd0);
        check("t3 read ov", {31'b0, ov}, 32'd0);

        // 4: pass marker
        txn(0, 32'h2000_0000, 32'd123456788, 4'b1111, rd, ov, od);
        check("t4 wrong value", {31'b0, tests_passed[0]}, 32'd0);
        txn(0, 32'h2000_0000, 32'd123456789, 4'b0111, rd, ov, od);
        check("t4 partial strobe", {31'b0, tests_passed[0]}, 32'd0);
        txn(0, 32'h2000_0000, 32'd123456789, 4'b1111, rd, ov, od);
        check("t4 passed", {31'b0, tests_passed[0]}, 32'd1);
        txn(0, 32'h2000_0000, 32'd0, 4'b0000, rd, ov, od);
        check("t4 readback", rd, 32'd1);

        // 5: out-of-bounds, first address kept
        check("t5 oob before", {31'b0, oob_error[0]}, 32'd0);
        txn(0, 32'h0002_0000, 32'h0, 4'b0000, rd, ov, od);
        check("t5 rd1", rd, 32'd0);
        txn(0, 32'h3000_0000, 32'h0, 4'b0000, rd, ov, od);
        check("t5 rd2", rd, 32'd0);
        check("t5 oob_error", {31'b0, oob_error[0]}, 32'd1);
        check("t5 oob_addr", oob_addr[0], 32'h0002_0000);

        // 6: protocol abort and reset during WAIT on the LATENCY=4 instance
        txn(2, 32'h300, 32'h55667788, 4'b1111, rd, ov, od);
        txn(2, 32'h1000_0000, 32'h5A, 4'b0001, rd, ov, od);
        txn(2, 32'h2000_0000, 32'd123456789, 4'b1111, rd, ov, od);
        txn(2, 32'h0800_0000, 32'h0, 4'b0000, rd, ov, od);
        @(posedge clk); #1;
        mem_valid[2] = 1'b1; mem_addr[2] = 32'h300; mem_wdata[2] = 32'hFFFFFFFF; mem_wstrb[2] = 4'b1111;
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; seen |= mem_ready[2]; end
        mem_valid[2] = 1'b0; mem_wstrb[2] = 4'b0000;
        repeat (4) begin @(posedge clk); #1; seen |= mem_ready[2]; end
        check("t6 proto_error", {31'b0, proto_error[2]}, 32'd1);
        check("t6 no ready", {31'b0, seen}, 32'd0);
        $display("txn d2 addr=00000300 aborted in WAIT proto_error=%0b", proto_error[2]);
        txn(2, 32'h300, 32'h0, 4'b0000, rd, ov, od);
        check("t6 no write", rd, 32'h55667788);

        @(posedge clk); #1;
        mem_valid[2] = 1'b1; mem_addr[2] = 32'h300; mem_wdata[2] = 32'h0BADF00D; mem_wstrb[2] = 4'b1111;
        repeat (2) @(posedge clk);
        #1 resetn[2] = 1'b0;
        #1 check_cleared(2, "t6 midreset");
        @(posedge clk); #1;
        mem_valid[2] = 1'b0; mem_wstrb[2] = 4'b0000;
        resetn[2] = 1'b1;
        $display("txn d2 addr=00000300 abandoned by reset");
        txn(2, 32'h300, 32'h0, 4'b0000, rd, ov, od);
        check("t6 ram kept", rd, 32'h55667788);
        check("t6 proto after", {31'b0, proto_error[2]}, 32'd0);

        // Random traffic on the zero-latency instance against a word-array model
        for (int i = 0; i < 64; i++) begin
            mdl[i] = $urandom;
            txn(0, WIN_BASE + 32'(i * 4), mdl[i], 4'b1111, rd, ov, od);
        end
        for (int k = 0; k < 120; k++) begin
            op  = $urandom_range(0, 3);
            idx = $urandom_range(0, 63);
            a   = WIN_BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            wd  = $urandom;
            ws  = 4'($urandom_range(0, 15));
            case (op)
                0: begin
                    txn(0, a, wd, 4'b0000, rd, ov, od);
                    check("rnd read", rd, mdl[idx]);
                end
                1: begin
                    txn(0, a, wd, ws, rd, ov, od);
                    check("rnd prewrite", rd, mdl[idx]);
                    check("rnd ram ov", {31'b0, ov}, 32'd0);
                    expw = mdl[idx];
                    for (int b = 0; b < 4; b++) if (ws[b]) expw[8*b +: 8] = wd[8*b +: 8];
                    mdl[idx] = expw;
                end
                2: begin
                    txn(0, 32'h1000_0000, wd, 4'b0001, rd, ov, od);
                    check("rnd con ov", {31'b0, ov}, 32'd1);
                    check("rnd con od", {24'b0, od}, {24'b0, wd[7:0]});
                end
                default: begin
                    a = 32'h0004_0000 + 32'($urandom_range(0, 4095) * 4);
                    txn(0, a, wd, ws, rd, ov, od);
                    check("rnd oob rd", rd, 32'd0);
                    check("rnd oob first", oob_addr[0], 32'h0002_0000);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
